cnt_bcd_converter: RTL and testbench
====================================

Name: cnt_bcd_converter

Overview:
Downstream stage of the asynchronous up-counter. It takes the counter's binary output and converts it to packed BCD digits for display or logging logic. Conversion is sequential: iterative shift-add-3 (double dabble), one bit per clock. Valid/ready handshakes are used on both input and output.

Parameters:
IN_W, 8, width of binary input (matches counter out width)
NDIG, 3, number of BCD digits produced; must satisfy 10^NDIG > 2^IN_W - 1 (elaboration-time check, $error on violation)

Ports:
clk  input  1  rising-edge clock
areset  input  1  asynchronous active-low reset
in_valid  input  1  in_bin holds a value to convert
in_ready  output  1  block can accept a value (IDLE only)
in_bin  input  IN_W  binary value, typically counter out
out_valid  output  1  out_bcd holds a new result
out_ready  input  1  consumer accepts result
out_bcd  output  4*NDIG  packed BCD; digit 0 = bits [3:0] (units)
busy  output  1  high in SHIFT or HOLD

Behaviour:
- Reset (areset=0, async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_bcd=0, busy=0, shift/iteration registers=0.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE: in_ready=1. On in_valid=1 at edge: capture in_bin into bin shift register, clear BCD scratch, load iter=IN_W, go SHIFT. in_ready falls the same edge.
- SHIFT, one iteration per cycle: every scratch digit >=5 gets +3, then {scratch,bin} shifts left 1. iter decrements. On the iteration where iter reaches 0: copy scratch to out_bcd, set out_valid=1, go HOLD.
- Latency: capture at edge N, out_valid=1 after edge N+IN_W (8 cycles default).
- HOLD: out_valid=1, out_bcd stable. On out_ready=1 at edge: out_valid=0, go IDLE. No same-cycle bypass; in_ready rises the cycle after acceptance.
- out_bcd keeps the last result after the handshake. It changes only on the next completion or reset.
- in_valid while busy: ignored, not queued. out_ready while not out_valid: no effect.
- in_bin=0 gives all-zero digits. Max 2^IN_W-1 (255) gives 12'h255. No wrap or overflow possible given the NDIG check.
- Unused upper digits stay 0.
- areset asserted mid-SHIFT or mid-HOLD: immediate abort to reset values. The partial result is discarded.

Optional Feature:
Macro AUTO_TRIGGER_EN.
- Defined:
  - in_valid is ignored. In IDLE the block starts a conversion whenever in_bin differs from the last captured value, or on the first IDLE cycle after reset.
  - HOLD is skipped: out_valid is a one-cycle pulse on completion and out_ready is ignored. The FSM returns to IDLE the next cycle.
  - A last_bin register is added (reset 0; the first-after-reset flag forces one conversion).
- Undefined: handshake behaviour exactly as above. No last_bin register.

Test Plan:
- Reset then in_bin=8'd0, in_valid pulse -> out_valid after 8 cycles, out_bcd=12'h000, busy high 8 cycles then through HOLD.
- in_bin=8'd255 -> out_bcd=12'h255. in_bin=8'd99 -> 12'h099. in_bin=8'd100 -> 12'h100. Each with out_ready=1: out_valid high exactly 1 cycle, in_ready high the following cycle.
- Backpressure: convert 8'd42, hold out_ready=0 for 10 cycles while driving in_valid=1 with in_bin=8'd7 -> out_valid stays 1, out_bcd=12'h042, in_ready=0. Release out_ready, then 8'd7 is accepted -> 12'h007.
- Reset mid-op: start 8'd200, assert areset low 4 cycles after capture -> out_valid=0, out_bcd=0, busy=0 asynchronously. After release, in_ready=1 next cycle and a fresh 8'd13 gives 12'h013.
- Counter hookup: drive in_bin from the counter incrementing every 20 cycles, handshaking each value -> out_bcd sequence 000,001,002,…, decimal-correct across 009->010 and 099->100.
- AUTO_TRIGGER_EN build: in_bin steps 9->10 -> single out_valid pulse with out_bcd=12'h010. in_bin held constant 50 cycles -> no further pulses.

Source files
------------

// File: rtl/cnt_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Optional macro AUTO_TRIGGER_EN: self-triggers on input change, pulsed output.
module cnt_bcd_converter #(
  parameter int IN_W = 8,
  parameter int NDIG = 3
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*NDIG-1:0]   out_bcd,
  output logic                busy
);

  localparam int BW = 4 * NDIG;
  localparam int IW = $clog2(IN_W + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned MAXV = (64'd1 << IN_W) - 64'd1;

  generate
    if (pow10(NDIG) <= MAXV) begin : g_ndig_check
      $error("NDIG too small for IN_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IN_W-1:0] r_bin;
  logic [BW-1:0]   r_scr;
  logic [IW-1:0]   r_iter;
  logic [BW-1:0]   r_out_bcd;
  logic            r_out_valid;

  logic [BW-1:0]   w_adj;
  logic [BW-1:0]   w_scr_nx;
  logic [IN_W-1:0] w_bin_nx;
  logic            w_start;
  logic            w_done;

`ifdef AUTO_TRIGGER_EN
  logic [IN_W-1:0] r_last_bin;
  logic            r_first;

  assign w_start = (r_state == S_IDLE) &&
                   (r_first || (in_bin != r_last_bin));
`else
  assign w_start = (r_state == S_IDLE) && in_valid;
`endif

  assign w_done = (r_state == S_SHIFT) && (r_iter == IW'(1));

  always_comb begin
    w_adj = r_scr;
    for (int d = 0; d < NDIG; d++) begin
      if (r_scr[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
    end
  end

  assign w_scr_nx = {w_adj[BW-2:0], r_bin[IN_W-1]};
  assign w_bin_nx = {r_bin[IN_W-2:0], 1'b0};

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_done) begin
`ifdef AUTO_TRIGGER_EN
          w_next = S_IDLE;
`else
          w_next = S_HOLD;
`endif
        end
      end
      S_HOLD:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_bin       <= '0;
      r_scr       <= '0;
      r_iter      <= '0;
      r_out_bcd   <= '0;
      r_out_valid <= 1'b0;
`ifdef AUTO_TRIGGER_EN
      r_last_bin  <= '0;
      r_first     <= 1'b1;
`endif
    end else begin
`ifdef AUTO_TRIGGER_EN
      r_out_valid <= 1'b0;
`endif
      if (w_start) begin
        r_bin  <= in_bin;
        r_scr  <= '0;
        r_iter <= IW'(IN_W);
`ifdef AUTO_TRIGGER_EN
        r_last_bin <= in_bin;
        r_first    <= 1'b0;
`endif
      end else if (r_state == S_SHIFT) begin
        r_bin  <= w_bin_nx;
        r_scr  <= w_scr_nx;
        r_iter <= r_iter - IW'(1);
        if (w_done) begin
          r_out_bcd   <= w_scr_nx;
          r_out_valid <= 1'b1;
        end
      end
`ifndef AUTO_TRIGGER_EN
      else if ((r_state == S_HOLD) && out_ready) begin
        r_out_valid <= 1'b0;
      end
`endif
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_bcd   = r_out_bcd;

endmodule

// File: tb/tb_cnt_bcd_converter.sv
// Directed self-checking bench for cnt_bcd_converter.
// Covers handshake, latency, backpressure, reset abort and counter sweep.
module tb_cnt_bcd_converter;

  logic        clk = 1'b0;
  logic        areset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cnt_bcd_converter #(.IN_W(8), .NDIG(3)) dut (
    .clk       (clk),
    .areset    (areset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .busy      (busy)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] dec2bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic test_reset();
    areset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_bin = 8'd0;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        busy !== 1'b0 || out_bcd !== 12'h000) begin
      failures++;
      $display("FAIL reset: rdy=%b vld=%b busy=%b bcd=%h want 1 0 0 000",
               in_ready, out_valid, busy, out_bcd);
    end
    cycle();
    cycle();
    areset = 1'b1;
    cycle();
  endtask

`ifndef AUTO_TRIGGER_EN
  task automatic test_zero();
    int n;
    bit bad;
    out_ready = 1'b0;
    in_bin = 8'd0;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL zero_capture: rdy=%b busy=%b want 0 1",
               in_ready, busy);
    end
    bad = 0;
    for (n = 1; n <= 7; n++) begin
      cycle();
      if (out_valid !== 1'b0 || busy !== 1'b1) bad = 1;
    end
    cycle();
    checks++;
    if (bad || out_valid !== 1'b1 || out_bcd !== 12'h000) begin
      failures++;
      $display("FAIL zero_latency: early=%b vld=%b bcd=%h want 0 1 000",
               bad, out_valid, out_bcd);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL zero_hold: vld=%b busy=%b want 1 1", out_valid, busy);
    end
    out_ready = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_accept: vld=%b busy=%b rdy=%b want 0 0 1",
               out_valid, busy, in_ready);
    end
  endtask

  task automatic test_values();
    logic [7:0]  vin [3] = '{8'd255, 8'd99, 8'd100};
    logic [11:0] vexp[3] = '{12'h255, 12'h099, 12'h100};
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_bin = vin[i];
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
        cycle();
        n++;
      end
      checks++;
      if (n != 8 || out_bcd !== vexp[i]) begin
        failures++;
        $display("FAIL value_%0d: lat=%0d bcd=%h want lat=8 bcd=%h",
                 vin[i], n, out_bcd, vexp[i]);
      end
      cycle();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
          out_bcd !== vexp[i]) begin
        failures++;
        $display("FAIL value_%0d_after: vld=%b rdy=%b bcd=%h want 0 1 %h",
                 vin[i], out_valid, in_ready, out_bcd, vexp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit bad;
    out_ready = 1'b0;
    in_bin = 8'd42;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_bcd !== 12'h042) begin
      failures++;
      $display("FAIL bp_done: vld=%b bcd=%h want 1 042", out_valid, out_bcd);
    end
    in_bin = 8'd7;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (out_valid !== 1'b1 || out_bcd !== 12'h042 || in_ready !== 1'b0)
        bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_stall: vld=%b bcd=%h rdy=%b want 1 042 0",
               out_valid, out_bcd, in_ready);
    end
    out_ready = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 12'h042) begin
      failures++;
      $display("FAIL bp_release: vld=%b rdy=%b bcd=%h want 0 1 042",
               out_valid, in_ready, out_bcd);
    end
    cycle();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (n != 8 || out_bcd !== 12'h007) begin
      failures++;
      $display("FAIL bp_second: lat=%0d bcd=%h want lat=8 bcd=007",
               n, out_bcd);
    end
    cycle();
  endtask

  task automatic test_reset_midop();
    int n;
    out_ready = 1'b1;
    in_bin = 8'd200;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();
    areset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_bcd !== 12'h000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midop_abort: vld=%b bcd=%h busy=%b want 0 000 0",
               out_valid, out_bcd, busy);
    end
    cycle();
    cycle();
    areset = 1'b1;
    cycle();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midop_release: rdy=%b busy=%b vld=%b want 1 0 0",
               in_ready, busy, out_valid);
    end
    in_bin = 8'd13;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (n != 8 || out_bcd !== 12'h013) begin
      failures++;
      $display("FAIL midop_fresh: lat=%0d bcd=%h want lat=8 bcd=013",
               n, out_bcd);
    end
    cycle();
  endtask

  task automatic test_counter();
    int n;
    int used;
    logic [11:0] exp;
    out_ready = 1'b1;
    for (int v = 0; v <= 100; v++) begin
      exp = dec2bcd(v);
      in_bin = 8'(v);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      used = 1;
      n = 0;
      while (out_valid !== 1'b1 && n < 19) begin
        cycle();
        n++;
      end
      used += n;
      checks++;
      if (out_valid !== 1'b1 || out_bcd !== exp) begin
        failures++;
        $display("FAIL counter_%0d: vld=%b bcd=%h want 1 %h",
                 v, out_valid, out_bcd, exp);
      end
      while (used < 20) begin
        cycle();
        used++;
      end
    end
  endtask
`else
  task automatic test_auto();
    int n;
    int pulses;
    in_bin = 8'd9;
    areset = 1'b0;
    cycle();
    areset = 1'b1;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_bcd !== 12'h009) begin
      failures++;
      $display("FAIL auto_first: vld=%b bcd=%h want 1 009",
               out_valid, out_bcd);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL auto_pulse1: vld=%b want 0", out_valid);
    end
    in_bin = 8'd10;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_bcd !== 12'h010) begin
      failures++;
      $display("FAIL auto_step: vld=%b bcd=%h want 1 010",
               out_valid, out_bcd);
    end
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (out_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || out_bcd !== 12'h010) begin
      failures++;
      $display("FAIL auto_quiet: pulses=%0d bcd=%h want 0 010",
               pulses, out_bcd);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef AUTO_TRIGGER_EN
    test_zero();
    test_values();
    test_backpressure();
    test_reset_midop();
    test_counter();
`else
    test_auto();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
